regfile_wb_arbiter: RTL and testbench

//  Arbitrates the single register-file write port between the in-order pipeline

---
 rtl/regfile_wb_arbiter_if.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 64 ++++++
 tb/tb_regfile_wb_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Register-file write-port bundle: WB and LU requests in, arbitration
// responses and the registered register-file write port out.
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  wb_valid_i;
    logic [4:0]            wb_addr_i;
    logic [DATA_WIDTH-1:0] wb_data_i;
    logic                  stall_o;
    logic                  lu_valid_i;
    logic [4:0]            lu_addr_i;
    logic [DATA_WIDTH-1:0] lu_data_i;
    logic                  lu_ready_o;
    logic                  lu_drop_o;
    logic                  rd_wren_o;
    logic [4:0]            rd_addr_o;
    logic [DATA_WIDTH-1:0] rd_data_o;

    modport slave (
        input  wb_valid_i, wb_addr_i, wb_data_i,
        input  lu_valid_i, lu_addr_i, lu_data_i,
        output stall_o, lu_ready_o, lu_drop_o,
        output rd_wren_o, rd_addr_o, rd_data_o
    );

    modport master (
        output wb_valid_i, wb_addr_i, wb_data_i,
        output lu_valid_i, lu_addr_i, lu_data_i,
        input  stall_o, lu_ready_o, lu_drop_o,
        input  rd_wren_o, rd_addr_o, rd_data_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single register-file write port shared by the WB stage (priority) and a
// long-latency unit, with starvation protection and WAW drop of stale LU results.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    regfile_wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    // LU handshake: lu_* held stable while lu_valid_i=1 until a cycle with
    // lu_ready_o=1, which is the transfer (result written or dropped).
    // WB has no ready; stall_o=1 means "not taken, present the same write again".
    logic          wb_req, lu_req, lu_zero, waw, starved;
    logic          grant_wb, grant_lu, lu_consumed;
    logic [CW-1:0] starve_cnt, cnt_next;

    assign wb_req   = bus.wb_valid_i & (bus.wb_addr_i != 5'd0);
    assign lu_req   = bus.lu_valid_i & (bus.lu_addr_i != 5'd0);
    assign lu_zero  = bus.lu_valid_i & (bus.lu_addr_i == 5'd0);
    assign waw      = wb_req & lu_req & (bus.wb_addr_i == bus.lu_addr_i);
    assign starved  = wb_req & lu_req & ~waw & (starve_cnt == LIMIT_C);

    assign grant_lu    = lu_req & (~wb_req | starved);
    assign grant_wb    = wb_req & ~starved;
    assign lu_consumed = lu_zero | waw | grant_lu;

    assign bus.lu_ready_o = rst_ni & lu_consumed;
    assign bus.stall_o    = rst_ni & starved;

    // Only a held, unconsumed LU request can be losing, so every such cycle counts.
    always_comb begin
        cnt_next = starve_cnt;
        if (!bus.lu_valid_i || lu_consumed) begin
            cnt_next = '0;
        end else if (starve_cnt != LIMIT_C) begin
            cnt_next = starve_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.rd_wren_o <= 1'b0;
            bus.rd_addr_o <= 5'd0;
            bus.rd_data_o <= '0;
            bus.lu_drop_o <= 1'b0;
            starve_cnt    <= '0;
        end else begin
            bus.rd_wren_o <= grant_wb | grant_lu;
            bus.lu_drop_o <= waw;
            starve_cnt    <= cnt_next;
            if (grant_lu) begin
                bus.rd_addr_o <= bus.lu_addr_i;
                bus.rd_data_o <= bus.lu_data_i;
            end else if (grant_wb) begin
                bus.rd_addr_o <= bus.wb_addr_i;
                bus.rd_data_o <= bus.wb_data_i;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed reset/latency checks, then directed and
// random traffic scored against a per-cycle priority model.
module tb_regfile_wb_arbiter;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0]  comb_q[$];   // {stall, lu_ready} for the current cycle
    logic [38:0] exp_q[$];    // {wren, addr, data, drop} one cycle later
    bit          mon_en = 1'b0;

    int          m_cnt;
    logic [4:0]  m_last_addr;
    logic [DW-1:0] m_last_data;
    bit          m_stall, m_ready;
    int          n_stalls, n_drops;

    logic [1:0]  mon_c;
    logic [38:0] mon_r;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_last_addr = '0; m_last_data = '0;
        m_stall = 1'b0; m_ready = 1'b0;
        comb_q.delete(); exp_q.delete();
        exp_q.push_back(39'd0);
    endtask

    task automatic set_idle();
        bus.wb_valid_i = 1'b0; bus.wb_addr_i = '0; bus.wb_data_i = '0;
        bus.lu_valid_i = 1'b0; bus.lu_addr_i = '0; bus.lu_data_i = '0;
    endtask

    // One cycle: apply requests (honouring WB hold on stall and LU hold until
    // ready), then predict this cycle's responses and next cycle's write.
    task automatic drive(input bit wv, input logic [4:0] wa, input logic [DW-1:0] wd,
                         input bit lv, input logic [4:0] la, input logic [DW-1:0] ld);
        bit wr, lr, st, rdy, wen, drp;
        logic [4:0] a;
        logic [DW-1:0] d;
        @(posedge clk); #1;
        if (!m_stall) begin
            bus.wb_valid_i = wv; bus.wb_addr_i = wa; bus.wb_data_i = wd;
        end
        if (!(bus.lu_valid_i && !m_ready)) begin
            bus.lu_valid_i = lv; bus.lu_addr_i = la; bus.lu_data_i = ld;
        end
        wr = bus.wb_valid_i && bus.wb_addr_i != 0;
        lr = bus.lu_valid_i && bus.lu_addr_i != 0;
        st = 0; rdy = 0; wen = 0; drp = 0; a = m_last_addr; d = m_last_data;
        if (bus.lu_valid_i && bus.lu_addr_i == 0) begin
            rdy = 1; m_cnt = 0;
            if (wr) begin wen = 1; a = bus.wb_addr_i; d = bus.wb_data_i; end
        end else if (wr && lr && bus.wb_addr_i == bus.lu_addr_i) begin
            rdy = 1; drp = 1; m_cnt = 0; wen = 1; a = bus.wb_addr_i; d = bus.wb_data_i;
        end else if (wr && lr && m_cnt == LIMIT) begin
            rdy = 1; st = 1; m_cnt = 0; wen = 1; a = bus.lu_addr_i; d = bus.lu_data_i;
        end else if (wr && lr) begin
            wen = 1; a = bus.wb_addr_i; d = bus.wb_data_i;
            m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : LIMIT;
        end else if (wr) begin
            wen = 1; a = bus.wb_addr_i; d = bus.wb_data_i; m_cnt = 0;
        end else if (lr) begin
            rdy = 1; wen = 1; a = bus.lu_addr_i; d = bus.lu_data_i; m_cnt = 0;
        end else begin
            m_cnt = 0;
        end
        m_last_addr = a; m_last_data = d;
        m_stall = st; m_ready = rdy;
        if (st) n_stalls++;
        if (drp) n_drops++;
        comb_q.push_back({st, rdy});
        exp_q.push_back({wen, a, d, drp});
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (comb_q.size() == 0 || exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_underflow: got comb=%0d rd=%0d entries expected >=1",
                         comb_q.size(), exp_q.size());
            end else begin
                mon_c = comb_q.pop_front();
                mon_r = exp_q.pop_front();
                chk("stall_o",    64'(bus.stall_o),    64'(mon_c[1]));
                chk("lu_ready_o", 64'(bus.lu_ready_o), 64'(mon_c[0]));
                chk("rd_wren_o",  64'(bus.rd_wren_o),  64'(mon_r[38]));
                chk("rd_addr_o",  64'(bus.rd_addr_o),  64'(mon_r[37:33]));
                chk("rd_data_o",  64'(bus.rd_data_o),  64'(mon_r[32:1]));
                chk("lu_drop_o",  64'(bus.lu_drop_o),  64'(mon_r[0]));
            end
        end
    end

    initial begin
        n_stalls = 0; n_drops = 0;
        set_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        // Plain WB write, then async reset in the middle of a write cycle.
        @(posedge clk); #1;
        bus.wb_valid_i = 1'b1; bus.wb_addr_i = 5'd5; bus.wb_data_i = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("wb_rd_wren", 64'(bus.rd_wren_o), 64'd1);
        chk("wb_rd_addr", 64'(bus.rd_addr_o), 64'd5);
        chk("wb_rd_data", 64'(bus.rd_data_o), 64'hDEADBEEF);
        chk("wb_stall",   64'(bus.stall_o),   64'd0);
        bus.lu_valid_i = 1'b1; bus.lu_addr_i = 5'd9; bus.lu_data_i = 32'h77;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rd_wren",  64'(bus.rd_wren_o),  64'd0);
        chk("rst_rd_addr",  64'(bus.rd_addr_o),  64'd0);
        chk("rst_rd_data",  64'(bus.rd_data_o),  64'd0);
        chk("rst_lu_drop",  64'(bus.lu_drop_o),  64'd0);
        chk("rst_lu_ready", 64'(bus.lu_ready_o), 64'd0);
        chk("rst_stall",    64'(bus.stall_o),    64'd0);
        set_idle();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        model_reset();

        // Starvation: WB writes x1 every cycle while LU holds x7.
        for (int i = 0; i < 8; i++) drive(1, 5'd1, DW'(32'h100 + i), 1, 5'd7, 32'h1234);
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        // WAW on x3: WB value wins, LU value dropped.
        drive(1, 5'd3, 32'hA, 1, 5'd3, 32'hB);
        drive(0, 0, 0, 0, 0, 0);
        // LU to x0 alongside WB x2; then WB to x0 alone.
        drive(1, 5'd2, 32'h55, 1, 5'd0, 32'h99);
        drive(1, 5'd0, 32'h66, 0, 0, 0);
        // LU alone.
        drive(0, 0, 0, 1, 5'd9, 32'h77);
        drive(0, 0, 0, 0, 0, 0);

        // Random traffic, light then heavy WB load to exercise starvation.
        for (int i = 0; i < 2000; i++)
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
        for (int i = 0; i < 1500; i++)
            drive(1'b1, 5'($urandom_range(1, 31)), $urandom,
                  $urandom_range(0, 4) != 0, 5'($urandom_range(0, 31)), $urandom);
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        mon_en = 1'b0;

        n_checks++;
        if (n_stalls > 0 && n_drops > 0) n_pass++;
        else $display("FAIL coverage: got stalls=%0d drops=%0d expected both >0", n_stalls, n_drops);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
